// File: rtl/table_fetch_pkg.sv
// Shared types for the serialization-table fetcher and its ser_aggregate consumer.
package table_fetch_pkg;

    localparam int   DRAM_LANES  = 8;
    localparam int   ENTRY_BYTES = 16;
    localparam logic DRAM_RD     = 1'b0;

    typedef logic [ENTRY_BYTES*8-1:0] TABLE_ENTRY;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, PRESENT, FIN} state_e;

    // Progress of the look-ahead fetch into the second buffer.
    typedef enum logic [1:0] {PF_IDLE, PF_LO, PF_HI, PF_FULL} pf_e;

endpackage

// File: rtl/table_fetch_lane_gather.sv
// One 8-byte DRAM read beat: arms all lanes, collects bytes as lanes complete,
// flags the cycle the last outstanding lane returns.
module table_fetch_lane_gather
    import table_fetch_pkg::*;
#(
    parameter int LANES = DRAM_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic [63:0]            base,
    input  logic [LANES-1:0][7:0]  dram_data_in,
    input  logic [LANES-1:0]       dram_valid,
    output logic [LANES-1:0]       dram_en,
    output logic [LANES-1:0][63:0] dram_addr,
    output logic [LANES*8-1:0]     word,
    output logic                   beat_done
);

    logic [LANES-1:0]       en_q, en_d;
    logic [LANES-1:0][63:0] addr_q, addr_d;
    logic [LANES-1:0][7:0]  byte_q, byte_d;

    always_comb begin
        en_d   = en_q & ~dram_valid;
        addr_d = addr_q;
        byte_d = byte_q;
        for (int i = 0; i < LANES; i++) begin
            if (en_q[i] && dram_valid[i]) byte_d[i] = dram_data_in[i];
            if (arm) addr_d[i] = base + 64'(i);
        end
        // Re-arming wins over the clear so back-to-back beats need no gap.
        if (arm) en_d = '1;
    end

    assign beat_done = (en_q != '0) && ((en_q & ~dram_valid) == '0);
    assign word      = byte_d;
    assign dram_en   = en_q;
    assign dram_addr = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q   <= '0;
            addr_q <= '0;
            byte_q <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            byte_q <= byte_d;
        end
    end

endmodule

// File: rtl/table_fetch.sv
// Walks num_entries 16-byte descriptors from table_addr and hands them out on valid/ready.
// Build option TABLE_FETCH_PREFETCH_EN fetches entry k+1 while entry k waits for ready.
module table_fetch
    import table_fetch_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LANES = DRAM_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [63:0]            table_addr,
    input  logic [CNT_W-1:0]       num_entries,
    output logic                   busy,
    output logic                   done,
    output TABLE_ENTRY             entry,
    output logic                   entry_valid,
    input  logic                   entry_ready,
    output logic [LANES-1:0]       dram_en,
    output logic                   dram_rdwr,
    output logic [LANES-1:0][63:0] dram_addr,
    input  logic [LANES-1:0][7:0]  dram_data_in,
    input  logic [LANES-1:0]       dram_valid
);

    localparam int WORD_W = LANES * 8;

    state_e           state_q, state_d;
    logic [63:0]      base_q, base_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    TABLE_ENTRY       entry_q, entry_d;
    logic             entry_valid_q, entry_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic              arm;
    logic [63:0]       arm_base;
    logic [WORD_W-1:0] word;
    logic              beat_done;
    logic              last;

`ifdef TABLE_FETCH_PREFETCH_EN
    pf_e        pf_q, pf_d;
    TABLE_ENTRY buf_q, buf_d;
    logic       more;
    assign more = ({1'b0, cnt_q} + (CNT_W+1)'(2)) < {1'b0, num_q};
`endif

    table_fetch_lane_gather #(.LANES(LANES)) u_gather (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .base         (arm_base),
        .dram_data_in (dram_data_in),
        .dram_valid   (dram_valid),
        .dram_en      (dram_en),
        .dram_addr    (dram_addr),
        .word         (word),
        .beat_done    (beat_done)
    );

    assign last = (cnt_q == num_q - 1'b1);

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        cnt_d         = cnt_q;
        entry_d       = entry_q;
        entry_valid_d = entry_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        arm           = 1'b0;
        arm_base      = base_q;
`ifdef TABLE_FETCH_PREFETCH_EN
        pf_d          = pf_q;
        buf_d         = buf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                base_d = table_addr;
                num_d  = num_entries;
                cnt_d  = '0;
                busy_d = 1'b1;
                if (num_entries == '0) begin
                    state_d = FIN;
                end else begin
                    state_d  = RD_LO;
                    arm      = 1'b1;
                    arm_base = table_addr;
                end
            end
            RD_LO: if (beat_done) begin
                entry_d[ENTRY_BYTES*8-1 -: WORD_W] = word;
                arm      = 1'b1;
                arm_base = base_q + 64'd8;
                state_d  = RD_HI;
            end
            RD_HI: if (beat_done) begin
                entry_d[WORD_W-1:0] = word;
                entry_valid_d       = 1'b1;
                state_d             = PRESENT;
`ifdef TABLE_FETCH_PREFETCH_EN
                if (!last) begin
                    arm      = 1'b1;
                    arm_base = base_q + 64'd16;
                    pf_d     = PF_LO;
                end
`endif
            end
            PRESENT: begin
`ifdef TABLE_FETCH_PREFETCH_EN
                if (beat_done && pf_q == PF_LO) begin
                    buf_d[ENTRY_BYTES*8-1 -: WORD_W] = word;
                    arm      = 1'b1;
                    arm_base = base_q + 64'd24;
                    pf_d     = PF_HI;
                end else if (beat_done && pf_q == PF_HI) begin
                    buf_d[WORD_W-1:0] = word;
                    pf_d              = PF_FULL;
                end
`endif
                if (entry_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d       = FIN;
                        entry_valid_d = 1'b0;
                    end else begin
                        base_d = base_q + 64'd16;
`ifdef TABLE_FETCH_PREFETCH_EN
                        if (pf_d == PF_FULL) begin
                            entry_d = buf_d;
                            pf_d    = PF_IDLE;
                            if (more) begin
                                arm      = 1'b1;
                                arm_base = base_q + 64'd32;
                                pf_d     = PF_LO;
                            end
                        end else begin
                            // Partial prefetch: the gather keeps running, the main FSM picks it up.
                            entry_valid_d = 1'b0;
                            entry_d[ENTRY_BYTES*8-1 -: WORD_W] = buf_d[ENTRY_BYTES*8-1 -: WORD_W];
                            state_d = (pf_d == PF_LO) ? RD_LO : RD_HI;
                            pf_d    = PF_IDLE;
                        end
`else
                        entry_valid_d = 1'b0;
                        arm           = 1'b1;
                        arm_base      = base_q + 64'd16;
                        state_d       = RD_LO;
`endif
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            num_q         <= '0;
            cnt_q         <= '0;
            entry_q       <= '0;
            entry_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef TABLE_FETCH_PREFETCH_EN
            pf_q          <= PF_IDLE;
            buf_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_q         <= num_d;
            cnt_q         <= cnt_d;
            entry_q       <= entry_d;
            entry_valid_q <= entry_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef TABLE_FETCH_PREFETCH_EN
            pf_q          <= pf_d;
            buf_q         <= buf_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign entry       = entry_q;
    assign entry_valid = entry_valid_q;
    assign dram_rdwr   = DRAM_RD;

endmodule

// File: tb/tb_table_fetch.sv
// Bench for table_fetch: behavioural DRAM with per-lane latency, scoreboard of expected entries.
module tb_table_fetch;
    import table_fetch_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [63:0]      table_addr = '0;
    logic [15:0]      num_entries = '0;
    logic             busy, done, entry_valid, dram_rdwr;
    logic             entry_ready = 1'b0;
    TABLE_ENTRY       entry;
    logic [7:0]       dram_en;
    logic [7:0][63:0] dram_addr;
    logic [7:0][7:0]  dram_data_in = '0;
    logic [7:0]       dram_valid = '0;

    always #5 clk = ~clk;

    table_fetch dut (
        .clk(clk), .reset(reset), .start(start), .table_addr(table_addr),
        .num_entries(num_entries), .busy(busy), .done(done), .entry(entry),
        .entry_valid(entry_valid), .entry_ready(entry_ready), .dram_en(dram_en),
        .dram_rdwr(dram_rdwr), .dram_addr(dram_addr), .dram_data_in(dram_data_in),
        .dram_valid(dram_valid)
    );

    int n_chk = 0;
    int n_fail = 0;
    int lat [8];
    int w [8];
    int stall_tab [8];
    TABLE_ENTRY exp_q [$];
    logic [63:0] addr_log [$];
    int hs_cyc [$];
    int n_hs, n_done, n_busy, n_en;
    bit aborted;
    TABLE_ENTRY last_entry;

    function automatic logic [7:0] bmem(input logic [63:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo - 8'h10) ^ {4'h0, a[11:8]};
    endfunction

    function automatic TABLE_ENTRY exp_entry(input logic [63:0] b);
        TABLE_ENTRY e;
        for (int i = 0; i < 8; i++) begin
            e[64+8*i +: 8] = bmem(b + 64'(i));
            e[8*i +: 8]    = bmem(b + 64'(8 + i));
        end
        return e;
    endfunction

    // Lane i answers after its enable has been seen on lat[i]+1 falling edges.
    task automatic model_step(output logic [7:0] issued);
        issued = '0;
        for (int i = 0; i < 8; i++) begin
            if (dram_valid[i]) begin
                dram_valid[i] = 1'b0;
                w[i] = 0;
            end
            if (dram_en[i]) begin
                if (w[i] >= lat[i]) begin
                    dram_valid[i]   = 1'b1;
                    dram_data_in[i] = bmem(dram_addr[i]);
                    issued[i]       = 1'b1;
                end else begin
                    w[i]++;
                end
            end else begin
                w[i] = 0;
            end
        end
    endtask

    task automatic set_lat(input int l);
        for (int i = 0; i < 8; i++) begin
            lat[i] = l;
            w[i] = 0;
            stall_tab[i] = 0;
        end
    endtask

    task automatic run_fetch(input logic [63:0] addr, input logic [15:0] n, input logic [63:0] abort_addr);
        logic [7:0]  issued;
        logic        lo_end = 1'b0;
        logic [63:0] lo_addr = '0;
        logic        prev_stall = 1'b0;
        TABLE_ENTRY  prev_entry = '0;
        TABLE_ENTRY  exp;
        int          vcnt = 0;
        bit          fin = 0;
        n_hs = 0; n_done = 0; n_busy = 0; n_en = 0; aborted = 0;
        hs_cyc.delete();
        addr_log.delete();
        for (int k = 0; k < int'(n); k++) exp_q.push_back(exp_entry(addr + 64'(16 * k)));
        @(negedge clk);
        table_addr = addr; num_entries = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (busy) n_busy++;
            if (done) n_done++;
            if (dram_en != '0) n_en++;
            if (lo_end) begin
                n_chk++;
                if (dram_en !== 8'hFF || dram_addr[0] !== lo_addr + 64'd8) begin
                    n_fail++;
                    $display("FAIL hi_rearm: en=%h addr0=%h, expected en=ff addr0=%h", dram_en, dram_addr[0], lo_addr + 64'd8);
                end
            end
            if (prev_stall) begin
                n_chk++;
                if (entry_valid !== 1'b1 || entry !== prev_entry) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b entry=%h, expected valid=1 entry=%h", entry_valid, entry, prev_entry);
                end
            end
`ifndef TABLE_FETCH_PREFETCH_EN
            if (entry_valid) begin
                n_chk++;
                if (dram_en !== 8'h00) begin
                    n_fail++;
                    $display("FAIL en_in_present: dram_en=%h, expected 00", dram_en);
                end
            end
`endif
            if (done) begin
                fin = 1;
            end else if (abort_addr != '0 && dram_en != '0 && dram_addr[0] == abort_addr) begin
                #2 reset = 1'b1;
                #1;
                n_chk++;
                if ({busy, done, entry_valid, dram_rdwr} !== 4'b0 || entry !== '0 || dram_en !== '0 || dram_addr !== '0) begin
                    n_fail++;
                    $display("FAIL abort_outputs: busy=%b done=%b valid=%b en=%h entry=%h, expected all zero", busy, done, entry_valid, dram_en, entry);
                end
                dram_valid = '0;
                entry_ready = 1'b0;
                for (int i = 0; i < 8; i++) w[i] = 0;
                exp_q.delete();
                @(negedge clk);
                reset = 1'b0;
                aborted = 1;
                fin = 1;
            end else begin
                model_step(issued);
                lo_end  = (issued != '0) && ((dram_en & ~issued) == '0) && !dram_addr[0][3];
                lo_addr = dram_addr[0];
                if (issued[0]) addr_log.push_back(dram_addr[0]);
                if (entry_valid) vcnt++;
                entry_ready = entry_valid && (vcnt > ((n_hs < 8) ? stall_tab[n_hs] : 0));
                if (entry_valid && entry_ready) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL entry: got %h, expected no entry", entry);
                    end else begin
                        exp = exp_q.pop_front();
                        if (entry !== exp) begin
                            n_fail++;
                            $display("FAIL entry: got %h, expected %h", entry, exp);
                        end
                    end
                    last_entry = entry;
                    hs_cyc.push_back(cyc);
                    n_hs++;
                    vcnt = 0;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = entry_valid;
                end
                prev_entry = entry;
                @(negedge clk);
            end
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: done never seen, expected done pulse");
        end
        entry_ready = 1'b0;
        dram_valid = '0;
        if (!aborted) begin
            repeat (3) begin
                @(negedge clk);
                n_chk++;
                if (dram_en !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tail_idle: en=%h done=%b busy=%b, expected 00/0/0", dram_en, done, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, entry_valid, dram_rdwr} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/valid/rdwr=%b, expected 0000", {busy, done, entry_valid, dram_rdwr});
        end
        n_chk++;
        if (entry !== '0) begin
            n_fail++;
            $display("FAIL reset_entry: got %h, expected 0", entry);
        end
        n_chk++;
        if (dram_en !== '0 || dram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_dram: en=%h addr0=%h, expected 0", dram_en, dram_addr[0]);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_lat(1);
        run_fetch(64'h10, 16'd1, 64'h0);
        n_chk++;
        if (last_entry !== 128'h07060504030201000F0E0D0C0B0A0908) begin
            n_fail++;
            $display("FAIL single_value: got %h, expected 07060504030201000f0e0d0c0b0a0908", last_entry);
        end
        n_chk++;
        if (n_hs != 1 || n_done != 1) begin
            n_fail++;
            $display("FAIL single_counts: handshakes=%0d done=%0d, expected 1/1", n_hs, n_done);
        end
    endtask

    task automatic test_multi_stall();
        logic [63:0] want;
        set_lat(1);
        stall_tab[1] = 5;
        run_fetch(64'h100, 16'd3, 64'h0);
        n_chk++;
        if (n_hs != 3 || n_done != 1) begin
            n_fail++;
            $display("FAIL multi_counts: handshakes=%0d done=%0d, expected 3/1", n_hs, n_done);
        end
        n_chk++;
        if (addr_log.size() != 6) begin
            n_fail++;
            $display("FAIL multi_addr_len: got %0d beats, expected 6", addr_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                want = 64'h100 + 64'(8 * i);
                n_chk++;
                if (addr_log[i] !== want) begin
                    n_fail++;
                    $display("FAIL multi_addr[%0d]: got %h, expected %h", i, addr_log[i], want);
                end
            end
        end
    endtask

    task automatic test_zero();
        set_lat(1);
        run_fetch(64'h300, 16'd0, 64'h0);
        n_chk++;
        if (n_busy != 1 || n_done != 1 || n_en != 0 || n_hs != 0) begin
            n_fail++;
            $display("FAIL zero_entries: busy_cycles=%0d done=%0d en_cycles=%0d hs=%0d, expected 1/1/0/0", n_busy, n_done, n_en, n_hs);
        end
    endtask

    task automatic test_stagger();
        set_lat(1);
        lat[7] = 0; lat[6] = 1; lat[5] = 1; lat[4] = 2;
        lat[3] = 2; lat[2] = 3; lat[1] = 1; lat[0] = 4;
        run_fetch(64'h40, 16'd2, 64'h0);
        n_chk++;
        if (n_hs != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stagger_counts: handshakes=%0d left=%0d, expected 2/0", n_hs, exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        set_lat(1);
        run_fetch(64'h180, 16'd4, 64'h1A8);
        n_chk++;
        if (!aborted || n_done != 0 || n_hs != 2) begin
            n_fail++;
            $display("FAIL abort_counts: aborted=%0d done=%0d hs=%0d, expected 1/0/2", aborted, n_done, n_hs);
        end
        set_lat(1);
        run_fetch(64'h200, 16'd2, 64'h0);
        n_chk++;
        if (n_hs != 2 || n_done != 1) begin
            n_fail++;
            $display("FAIL restart_counts: hs=%0d done=%0d, expected 2/1", n_hs, n_done);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        set_lat(1);
        stall_tab[0] = 20;
        run_fetch(64'h80, 16'd2, 64'h0);
        gap = (hs_cyc.size() == 2) ? hs_cyc[1] - hs_cyc[0] : -1;
        n_chk++;
`ifdef TABLE_FETCH_PREFETCH_EN
        if (gap != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles, expected 1", gap);
        end
`else
        if (gap < 4) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles, expected at least 4", gap);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_multi_stall();
        test_zero();
        test_stagger();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/table_fetch.md
Name: table_fetch

Overview:
- Upstream feeder for ser_aggregate.
- Walks a serialization table in DRAM: num_entries consecutive 16-byte descriptors starting at table_addr.
- Reads each descriptor over the 8-lane byte DRAM port, assembles it into a TABLE_ENTRY and presents it on a valid/ready handshake that connects directly to ser_aggregate's entry/entry_valid/ready.

Parameters:
- CNT_W, 16, width of num_entries and the internal entry counter.
- LANES, 8, DRAM byte lanes used per read beat. Fixed at 8; ENTRY_BYTES/LANES = 2 beats per entry.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- table_addr  in  64  byte address of descriptor 0.
- num_entries  in  CNT_W  number of descriptors to fetch.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last entry handshake.
- entry  out  TABLE_ENTRY(128)  assembled descriptor.
- entry_valid  out  1  entry holds a descriptor.
- entry_ready  in  1  consumer (ser_aggregate.ready) accepts.
- dram_en  out  8  per-lane request.
- dram_rdwr  out  1  constant 0 (read).
- dram_addr  out  8x64  per-lane byte address.
- dram_data_in  in  8x8  per-lane read data.
- dram_valid  in  8  per-lane data valid.

Behaviour:
- Reset values: busy=0, done=0, entry_valid=0, entry=0, dram_en=0, dram_rdwr=0, dram_addr=0, counter=0, state=IDLE.
- Reset asserted mid-operation aborts immediately: dram_en drops, no done pulse, any partial entry is discarded.
- States: IDLE, RD_LO, RD_HI, PRESENT, FIN.
- IDLE:
  - start=1 latches table_addr and num_entries and sets busy.
  - num_entries=0 -> FIN, so done pulses one cycle after busy rises, with no DRAM access.
  - Otherwise -> RD_LO.
  - start in any other state is ignored.
- Entry address: entry k base = table_addr + 16*k, computed modulo 2^64 (wrap allowed, no error).
- RD_LO, RD_HI (read beats):
  - Lane i drives dram_addr[i] = base + i (LO) or base + 8 + i (HI).
  - All dram_en lanes assert on state entry.
  - On dram_valid[i], byte i is captured and dram_en[i] clears the next cycle.
  - Lanes may complete in any order or in the same cycle.
  - The beat ends on the cycle the last outstanding lane is valid. The next state is entered at the following posedge with dram_en re-armed; there are no idle cycles between LO and HI.
  - dram_valid on a lane not enabled is ignored.
- Packing:
  - entry[127:64] = LO bytes, little-endian: byte i at [64+8i +: 8].
  - entry[63:0] = HI bytes, little-endian.
- PRESENT:
  - entry_valid=1; entry is stable until the handshake.
  - Transfer occurs on a posedge with entry_valid & entry_ready.
  - After transfer the counter increments. If counter == num_entries-1 -> FIN, else -> RD_LO for the next entry.
  - entry_valid drops the cycle after transfer.
- FIN: done=1 for one cycle, busy=0 from the next cycle, -> IDLE.
- dram_en is never high outside RD_LO/RD_HI (non-prefetch build).

Optional Feature:
- Macro: TABLE_FETCH_PREFETCH_EN.
- Defined:
  - A second 128-bit buffer is added.
  - While PRESENT waits on entry_ready, the fetch of entry k+1 proceeds into the buffer, provided k+1 < num_entries.
  - On handshake, a completed buffer loads into entry and entry_valid stays high (back-to-back transfers).
  - An incomplete buffer continues the fetch; entry_valid drops until it completes.
  - Never more than one entry is prefetched.
- Undefined: strictly serial behaviour as above. The buffer logic is absent.

Decomposition:
- Shared package (the same one defining TABLE_ENTRY):
  - TABLE_ENTRY typedef.
  - DRAM_LANES=8, ENTRY_BYTES=16.
  - DRAM_RD=1'b0 encoding.
- Sub-module lane_gather:
  - Inputs: arm, base addr.
  - Handles per-lane dram_en/addr, captures bytes on dram_valid, outputs a 64-bit word plus a one-cycle beat_done.
  - Instanced once and reused for the LO and HI beats.

Test Plan:
- Single entry, table_addr=0x10, DRAM bytes 0x10..0x1F = 0x00..0x0F, all lanes valid 1 cycle after en, entry_ready=1 -> entry = 0x07060504030201000F0E0D0C0B0A0908, one handshake, done pulses once, dram_en=0 afterwards.
- num_entries=3 at 0x100, entry_ready held low 5 cycles on entry 1 -> entry stable while stalled, exactly 3 handshakes, dram_addr lane0 = 0x100, 0x108, 0x110, 0x118, 0x120, 0x128 in order.
- num_entries=0 -> busy high 1 cycle, done pulse, dram_en never asserted.
- Staggered valid (lane 7 first, lane 0 last, two lanes in the same cycle) -> every byte lands in its lane slot, HI beat starts the cycle after lane 0 completes.
- Reset asserted during RD_HI of entry 2 -> all outputs return to reset values asynchronously. A subsequent start at 0x200 fetches correctly from entry 0.
- With TABLE_FETCH_PREFETCH_EN, 2 entries, entry_ready low 20 cycles then high 2 cycles -> two handshakes on consecutive cycles. Without the macro, ≥3 DRAM cycles separate them.
